// File: rtl/fbcd_pkg.sv
// Shared types and constants for the BCD-fraction to binary-fraction converter.
// The ROUND state exists only when FBCD_ROUND_EN is defined.
package fbcd_pkg;

    localparam int                     BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX     = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef FBCD_ROUND_EN
        ROUND = 2'd2,
`endif
        DONE  = 2'd3
    } fbcd_state_e;

    function automatic logic digit_bad(input logic [BCD_DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/fbcd_fbin_seq_bcd_dbl_digit.sv
// One BCD digit of the doubling chain: digit_out/cout = 2*d + cin, decimal-corrected.
module bcd_dbl_digit
    import fbcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] d,
    input  logic                   cin,
    output logic [BCD_DIGIT_W-1:0] digit_out,
    output logic                   cout
);

    logic [BCD_DIGIT_W:0] sum;

    assign sum  = {d, cin};
    assign cout = (sum >= 5'd10);
    // Subtracting 10 modulo 16 is the same as adding 6 to the low nibble.
    assign digit_out = sum[BCD_DIGIT_W-1:0] + (cout ? 4'd6 : 4'd0);

endmodule

// File: rtl/fbcd_fbin_seq.sv
// Sequential BCD fraction (0.d1..dN) to binary fraction converter by repeated BCD doubling.
// Define FBCD_ROUND_EN to add a round-half-up ROUND cycle with saturation.
//
//   state | meaning
//   IDLE  | ready, waiting for start
//   SHIFT | one result bit per cycle, MSB first; bad digit aborts to DONE
//   ROUND | (FBCD_ROUND_EN only) add guard bit, saturate at all-ones
//   DONE  | valid pulse, result held until next accepted start
module fbcd_fbin_seq
    import fbcd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int FRAC_BITS = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                          ready,
    output logic                          valid,
    output logic [FRAC_BITS-1:0]          bin_out,
    output logic                          err
);

    localparam int W     = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(FRAC_BITS + 1);

    fbcd_state_e          state_q, state_d;
    logic [W-1:0]         digits_q, digits_d;
    logic [W-1:0]         digits_dbl;
    logic [FRAC_BITS-1:0] bin_q, bin_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [DIGITS:0]      carry;
    logic                 any_bad;

    // Carry ripples from the least significant digit (bits [3:0]) up to d1.
    assign carry[0] = 1'b0;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dbl
        bcd_dbl_digit u_dbl (
            .d         (digits_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cin       (carry[g]),
            .digit_out (digits_dbl[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .cout      (carry[g+1])
        );
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_bad(digits_q[i*BCD_DIGIT_W +: BCD_DIGIT_W])) any_bad = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    digits_d = bcd_in;
                    bin_d    = '0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (any_bad) begin
                    err_d   = 1'b1;
                    bin_d   = '0;
                    state_d = DONE;
                end else begin
                    digits_d = digits_dbl;
                    bin_d    = {bin_q[FRAC_BITS-2:0], carry[DIGITS]};
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAC_BITS - 1)) begin
`ifdef FBCD_ROUND_EN
                        state_d = ROUND;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef FBCD_ROUND_EN
            ROUND: begin
                // One more doubling gives the guard bit.
                if (!(&bin_q)) bin_d = bin_q + FRAC_BITS'(carry[DIGITS]);
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            digits_q <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign ready   = (state_q == IDLE);
    assign valid   = (state_q == DONE);
    assign bin_out = bin_q;
    assign err     = err_q;

endmodule
